keypad_row_scanner: RTL and testbench

- Upstream sequencer that drives the 2-to-4 row decoder (EN, A1, A0) to scan a 4x4 keypad one row at a time.
- Samples the four column sense lines while each row is selected and debounces across successive scans.
- Reports each debounced key press as a 4-bit key code on a valid/ready handshake to downstream logic.

---
 rtl/keypad_row_scanner.sv | 186 ++++++++++++++++++
 tb/tb_keypad_row_scanner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_row_scanner.sv
// Row sequencer and debouncer for a 4x4 keypad behind a 2-to-4 row decoder.
// Optional macro KEYPAD_RELEASE_EVENT_EN adds key_release and release events.
module keypad_row_scanner #(
  parameter int unsigned DWELL_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_SCANS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       EN,
  output logic       A1,
  output logic       A0,
  input  logic [3:0] COL,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
`ifdef KEYPAD_RELEASE_EVENT_EN
  output logic       key_release,
`endif
  output logic       overrun
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);
  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

  function automatic logic is_single(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[1]) idx = 2'd1;
    if (v[2]) idx = 2'd2;
    if (v[3]) idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [7:0] dwell_q, dwell_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] match_q, match_d;
  logic       rep_q, rep_d;
  logic       key_valid_q, key_valid_d;
  logic [3:0] key_code_q, key_code_d;
  logic       overrun_q, overrun_d;
  logic       ev;
  logic [3:0] ev_code;
  logic [3:0] sample_key;
`ifdef KEYPAD_RELEASE_EVENT_EN
  logic       key_release_q, key_release_d;
  logic       ev_rel;
`endif

  assign sample_key = {row_q, col_index(COL)};

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    cand_d      = cand_q;
    match_d     = match_q;
    rep_d       = rep_q;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overrun_d   = 1'b0;
    ev          = 1'b0;
    ev_code     = cand_q;
`ifdef KEYPAD_RELEASE_EVENT_EN
    key_release_d = key_release_q;
    ev_rel        = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = SCAN;
          row_d   = 2'd0;
          dwell_d = 8'd0;
        end
      end
      SCAN: begin
        if (!run) begin
          state_d = IDLE;
          row_d   = 2'd0;
          dwell_d = 8'd0;
          cand_d  = 4'd0;
          match_d = 4'd0;
          rep_d   = 1'b0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = 8'd0;
          row_d   = row_q + 2'd1;
          if (is_single(COL) && (sample_key == cand_q)) begin
            match_d = sat_inc(match_q);
          end else if (is_single(COL)) begin
            cand_d  = sample_key;
            match_d = 4'd1;
            rep_d   = 1'b0;
          end else if (row_q == cand_q[3:2]) begin
            // Empty or ghosted sample on the candidate's own row breaks the streak
            match_d = 4'd0;
            rep_d   = 1'b0;
          end
          if ((match_d == DEB_TARGET) && !rep_d) begin
            ev      = 1'b1;
            ev_code = cand_d;
            rep_d   = 1'b1;
          end
`ifdef KEYPAD_RELEASE_EVENT_EN
          // A release of the old key outranks a simultaneous new press on that row
          if (rep_q && (row_q == cand_q[3:2]) && !COL[cand_q[1:0]]) begin
            ev      = 1'b1;
            ev_code = cand_q;
            ev_rel  = 1'b1;
          end
`endif
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ev) begin
      if (!key_valid_q || key_ready) begin
        key_valid_d = 1'b1;
        key_code_d  = ev_code;
`ifdef KEYPAD_RELEASE_EVENT_EN
        key_release_d = ev_rel;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_valid_q && key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= 2'd0;
      dwell_q     <= 8'd0;
      cand_q      <= 4'd0;
      match_q     <= 4'd0;
      rep_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      key_release_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      cand_q      <= cand_d;
      match_q     <= match_d;
      rep_q       <= rep_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overrun_q   <= overrun_d;
`ifdef KEYPAD_RELEASE_EVENT_EN
      key_release_q <= key_release_d;
`endif
    end
  end

  assign EN        = (state_q == SCAN);
  assign A1        = row_q[1];
  assign A0        = row_q[0];
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overrun   = overrun_q;
`ifdef KEYPAD_RELEASE_EVENT_EN
  assign key_release = key_release_q;
`endif

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Bench for keypad_row_scanner: a 4x4 key matrix model drives COL from the row
// select; expected key codes are queued as presses are applied.
module tb_keypad_row_scanner;

  logic       clk = 1'b0;
  logic       rst, run, key_ready;
  logic       en, a1, a0, key_valid, overrun;
  logic [3:0] col, key_code;
  logic [3:0] keys [4];
`ifdef KEYPAD_RELEASE_EVENT_EN
  logic       key_release;
`endif

  int errors = 0;
  int checks = 0;
  int ov_cnt = 0;
  int evt_cnt = 0;
  logic [3:0] exp_q [$];
  logic       hold_prev = 1'b0;
  logic [3:0] prev_code = 4'd0;

  keypad_row_scanner #(.DWELL_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .EN        (en),
    .A1        (a1),
    .A0        (a0),
    .COL       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
`ifdef KEYPAD_RELEASE_EVENT_EN
    .key_release (key_release),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  assign col = en ? keys[{a1, a0}] : 4'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int r, input int c, input int visits);
    keys[r][c] = 1'b1;
    tick(16 * visits);
    keys[r][c] = 1'b0;
  endtask

  task automatic wait_row(input logic [1:0] r);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (en && ({a1, a0} == r)) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check_val("wait_row", 32'(found), 32'd1);
  endtask

  // Output monitor: sampled on the falling edge, mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ov_cnt++;
      if (hold_prev) check_val("code_hold", 32'(key_code), 32'(prev_code));
      if (key_valid && key_ready) begin
        evt_cnt++;
        if (exp_q.size() == 0) check_val("spurious_evt", 32'(exp_q.size()), 32'd1);
        else check_val("key_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
      hold_prev = key_valid && !key_ready;
      prev_code = key_code;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) keys[i] = 4'd0;
    tick(2);
    check_val("rst_en", 32'(en), 32'd0);
    check_val("rst_addr", 32'({a1, a0}), 32'd0);
    check_val("rst_valid", 32'(key_valid), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    check_val("rst_code", 32'(key_code), 32'd0);
    rst = 1'b0;
    tick(1);
    check_val("idle_en", 32'(en), 32'd0);

    run = 1'b1;
    tick(1);
    check_val("en_on", 32'(en), 32'd1);
    check_val("row_first", 32'({a1, a0}), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick(4);
      check_val("row_step", 32'({a1, a0}), 32'(k % 4));
    end

    // Held key reports exactly once
    exp_q.push_back(4'b1010);
    press(2, 2, 4);
    tick(32);
    check_val("held_drain", 32'(exp_q.size()), 32'd0);
    check_val("held_count", 32'(evt_cnt), 32'd1);

    // Press, release for one scan, press again
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b1010);
    press(2, 2, 2);
    tick(16);
    press(2, 2, 2);
    tick(32);
    check_val("repress_drain", 32'(exp_q.size()), 32'd0);
    check_val("repress_count", 32'(evt_cnt), 32'd3);

    // Ghosted row and a single-scan glitch
    keys[1] = 4'b0110;
    tick(48);
    keys[1] = 4'd0;
    press(3, 0, 1);
    tick(32);
    check_val("ghost_glitch_count", 32'(evt_cnt), 32'd3);

    // Occupied output drops the second event
    key_ready = 1'b0;
    exp_q.push_back(4'b0000);
    press(0, 0, 2);
    press(3, 3, 2);
    tick(8);
    check_val("ovr_valid", 32'(key_valid), 32'd1);
    check_val("ovr_code", 32'(key_code), 32'd0);
    check_val("ovr_pulses", 32'(ov_cnt), 32'd1);
    key_ready = 1'b1;
    tick(1);
    check_val("ovr_consumed", 32'(key_valid), 32'd0);
    check_val("ovr_count", 32'(evt_cnt), 32'd4);

    // Stop mid-dwell with a pending event
    key_ready = 1'b0;
    exp_q.push_back(4'b1010);
    press(2, 2, 2);
    wait_row(2'd2);
    tick(1);
    run = 1'b0;
    tick(1);
    check_val("stop_en", 32'(en), 32'd0);
    check_val("stop_addr", 32'({a1, a0}), 32'd0);
    check_val("stop_valid", 32'(key_valid), 32'd1);
    check_val("stop_code", 32'(key_code), 32'(4'b1010));
    tick(5);
    check_val("stop_valid_held", 32'(key_valid), 32'd1);
    key_ready = 1'b1;
    tick(2);
    check_val("stop_drain", 32'(exp_q.size()), 32'd0);
    check_val("stop_valid_clear", 32'(key_valid), 32'd0);
    check_val("final_count", 32'(evt_cnt), 32'd5);
    check_val("final_overruns", 32'(ov_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
